// File: rtl/nec_key_events.sv
// Turns NEC decoder frames into press/repeat/release key events,
// queued in a first-word-fall-through FIFO with a valid/ready drain.
module nec_key_events #(
  parameter int unsigned CLOCK_INPUT     = 25000000,
  parameter logic [7:0]  DEVICE_ADDR     = 8'h00,
  parameter int unsigned ADDR_FILTER     = 1,
  parameter int unsigned REPEAT_DELAY_MS = 400,
  parameter int unsigned RELEASE_MS      = 250,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    address,
  input  logic [7:0]                    data,
  input  logic                          dataready,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [1:0]                    ev_type,
  output logic [7:0]                    ev_code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          key_held,
  output logic [7:0]                    held_code
);

  localparam int unsigned TICKS_PER_MS = CLOCK_INPUT / 1000;
  localparam int unsigned PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 10;

  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_REPEAT  = 2'b10;
  localparam logic [1:0] EV_RELEASE = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_SWAP} state_t;

  state_t          state_q, state_d;
  logic            dr_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     idle_ms_q, idle_ms_d;
  logic [15:0]     press_ms_q, press_ms_d;
  logic [7:0]      held_code_q, held_code_d;
  logic            key_held_q, key_held_d;
  logic            push_q, push_d;
  logic [EW-1:0]   push_ev_q, push_ev_d;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;
  logic [EW-1:0]   head_q, head_d;

  logic rise, accept, ms_tick, clr_idle, clr_press;
  logic pop, full, wr;

  assign rise    = dataready & ~dr_q;
  assign accept  = rise & ((ADDR_FILTER == 0) || (address == DEVICE_ADDR));
  assign ms_tick = (presc_q == PW'(TICKS_PER_MS - 1));

  // Key state machine: decides which event (if any) to push next cycle.
  always_comb begin
    state_d     = state_q;
    held_code_d = held_code_q;
    push_d      = 1'b0;
    push_ev_d   = push_ev_q;
    clr_idle    = 1'b0;
    clr_press   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          push_d      = 1'b1;
          push_ev_d   = {EV_PRESS, data};
          held_code_d = data;
          clr_idle    = 1'b1;
          clr_press   = 1'b1;
          state_d     = S_HELD;
        end
      end
      S_HELD: begin
        if (accept) begin
          if (data == held_code_q) begin
            clr_idle = 1'b1;
            if (press_ms_q >= 16'(REPEAT_DELAY_MS)) begin
              push_d    = 1'b1;
              push_ev_d = {EV_REPEAT, held_code_q};
            end
          end else begin
            push_d      = 1'b1;
            push_ev_d   = {EV_RELEASE, held_code_q};
            held_code_d = data;
            clr_idle    = 1'b1;
            clr_press   = 1'b1;
            state_d     = S_SWAP;
          end
        end else if (idle_ms_q >= 16'(RELEASE_MS)) begin
          push_d    = 1'b1;
          push_ev_d = {EV_RELEASE, held_code_q};
          state_d   = S_IDLE;
        end
      end
      S_SWAP: begin
        push_d    = 1'b1;
        push_ev_d = {EV_PRESS, held_code_q};
        state_d   = S_HELD;
      end
      default: state_d = S_IDLE;
    endcase
    key_held_d = (state_d == S_HELD) || (state_d == S_SWAP);
  end

  // Free-running ms prescaler and saturating ms timers.
  always_comb begin
    presc_d    = ms_tick ? '0 : presc_q + PW'(1);
    idle_ms_d  = idle_ms_q;
    press_ms_d = press_ms_q;
    if (clr_idle)
      idle_ms_d = '0;
    else if (ms_tick && (idle_ms_q != 16'hFFFF))
      idle_ms_d = idle_ms_q + 16'd1;
    if (clr_press)
      press_ms_d = '0;
    else if (ms_tick && (press_ms_q != 16'hFFFF))
      press_ms_d = press_ms_q + 16'd1;
  end

  // FIFO bookkeeping; the head register is preloaded so outputs stay registered.
  always_comb begin
    pop      = valid_q & ev_ready;
    full     = (count_q == CW'(FIFO_DEPTH));
    wr       = push_q & (~full | pop);
    ovf_d    = ovf_q | (push_q & full & ~pop);
    wr_ptr_d = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr) - CW'(pop);
    valid_d  = (count_d != '0);
    head_d   = head_q;
    if (count_d != '0)
      head_d = (wr && (rd_ptr_d == wr_ptr_q)) ? push_ev_q : mem[rd_ptr_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dr_q        <= 1'b1;
      presc_q     <= '0;
      idle_ms_q   <= '0;
      press_ms_q  <= '0;
      held_code_q <= '0;
      key_held_q  <= 1'b0;
      push_q      <= 1'b0;
      push_ev_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
      head_q      <= '0;
    end else begin
      dr_q        <= dataready;
      presc_q     <= presc_d;
      idle_ms_q   <= idle_ms_d;
      press_ms_q  <= press_ms_d;
      held_code_q <= held_code_d;
      key_held_q  <= key_held_d;
      push_q      <= push_d;
      push_ev_q   <= push_ev_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
      head_q      <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= push_ev_q;
  end

  assign ev_valid   = valid_q;
  assign ev_type    = head_q[EW-1:8];
  assign ev_code    = head_q[7:0];
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign key_held   = key_held_q;
  assign held_code  = held_code_q;

endmodule

// File: tb/tb_nec_key_events.sv
// Directed and randomized key-event checks against an event-level model
// that works from elapsed clock cycles rather than the design's timers.
module tb_nec_key_events;

  localparam longint CLK_PER = 10;
  localparam logic [1:0] T_PRESS = 2'b01, T_REPEAT = 2'b10, T_RELEASE = 2'b11;
  // Thresholds in cycles (10 clk/ms) with margins around the 25 ms / 40 ms limits.
  localparam longint HOLD_MAX = 215, REL_MIN = 285, REP_NO = 370, REP_YES = 430;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] address = 8'h00, data = 8'h00;
  logic       dataready = 1'b0;
  logic       ev_ready = 1'b1;
  logic       ev_valid, overflow, key_held;
  logic [1:0] ev_type;
  logic [7:0] ev_code, held_code;
  logic [2:0] fifo_count;
  logic       nf_ev_valid, nf_overflow, nf_key_held;
  logic       nf_ev_ready = 1'b1;
  logic [1:0] nf_ev_type;
  logic [7:0] nf_ev_code, nf_held_code;
  logic [2:0] nf_fifo_count;

  always #5 clk = ~clk;

  nec_key_events #(.CLOCK_INPUT(10000), .DEVICE_ADDR(8'h00), .ADDR_FILTER(1),
                   .REPEAT_DELAY_MS(40), .RELEASE_MS(25), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .address(address), .data(data), .dataready(dataready),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type), .ev_code(ev_code),
    .fifo_count(fifo_count), .overflow(overflow), .key_held(key_held),
    .held_code(held_code));

  nec_key_events #(.CLOCK_INPUT(10000), .DEVICE_ADDR(8'h00), .ADDR_FILTER(0),
                   .REPEAT_DELAY_MS(40), .RELEASE_MS(25), .FIFO_DEPTH(4)) dut_nf (
    .clk(clk), .rst(rst), .address(address), .data(data), .dataready(dataready),
    .ev_valid(nf_ev_valid), .ev_ready(nf_ev_ready), .ev_type(nf_ev_type),
    .ev_code(nf_ev_code), .fifo_count(nf_fifo_count), .overflow(nf_overflow),
    .key_held(nf_key_held), .held_code(nf_held_code));

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  longint     obs_cyc[$];
  bit         m_held = 1'b0;
  logic [7:0] m_code = 8'h00;
  longint     m_press = 0, m_last = 0;
  bit         exp_ovf = 1'b0;

  function automatic longint now_cyc();
    return longint'($time) / CLK_PER;
  endfunction

  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      obs_q.push_back({ev_type, ev_code});
      obs_cyc.push_back(now_cyc());
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Event model: consumer-side FIFO of capacity 4 only matters while stalled.
  function automatic void model_push(input logic [1:0] t, input logic [7:0] c);
    if (!ev_ready && (exp_q.size() - obs_q.size()) >= 4) exp_ovf = 1'b1;
    else exp_q.push_back({t, c});
  endfunction

  function automatic void model_advance(input longint t);
    if (m_held && (t - m_last) >= REL_MIN) begin
      model_push(T_RELEASE, m_code);
      m_held = 1'b0;
    end
  endfunction

  function automatic void model_edge(input logic [7:0] a, input logic [7:0] d, input longint t);
    if (a != 8'h00) return;
    model_advance(t);
    if (!m_held) begin
      model_push(T_PRESS, d);
      m_held = 1'b1; m_code = d; m_press = t; m_last = t;
    end else if (d == m_code) begin
      m_last = t;
      if ((t - m_press) >= REP_YES) model_push(T_REPEAT, m_code);
    end else begin
      model_push(T_RELEASE, m_code);
      model_push(T_PRESS, d);
      m_code = d; m_press = t; m_last = t;
    end
  endfunction

  task automatic drive_edge(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    address = a; data = d; dataready = 1'b1;
    model_edge(a, d, now_cyc());
  endtask

  task automatic end_pulse();
    repeat (3) @(posedge clk);
    #1 dataready = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d);
    drive_edge(a, d);
    end_pulse();
  endtask

  task automatic wait_ms(input int n);
    repeat (n * 10) @(posedge clk);
  endtask

  task automatic checkpoint(input string tag);
    int n;
    @(negedge clk);
    model_advance(now_cyc());
    chk({tag, "_held"}, 32'(key_held), 32'(m_held));
    chk({tag, "_nevents"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_ev%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete(); exp_q.delete(); obs_cyc.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ev_valid"},   32'(ev_valid),   32'(0));
    chk({tag, "_ev_type"},    32'(ev_type),    32'(0));
    chk({tag, "_ev_code"},    32'(ev_code),    32'(0));
    chk({tag, "_fifo_count"}, 32'(fifo_count), 32'(0));
    chk({tag, "_overflow"},   32'(overflow),   32'(0));
    chk({tag, "_key_held"},   32'(key_held),   32'(0));
    chk({tag, "_held_code"},  32'(held_code),  32'(0));
  endtask

  initial begin
    int w;
    logic [7:0] a, d;
    longint te, dd, ss;

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // Single press: latency N+2, then release after the hold timeout.
    drive_edge(8'h00, 8'h45);
    @(negedge clk); chk("lat_n_valid", 32'(ev_valid), 32'(0));
    @(negedge clk); chk("lat_n1_valid", 32'(ev_valid), 32'(0));
    chk("lat_n1_held", 32'(key_held), 32'(1));
    @(negedge clk); chk("lat_n2_valid", 32'(ev_valid), 32'(1));
    chk("lat_n2_type", 32'(ev_type), 32'(T_PRESS));
    chk("lat_n2_code", 32'(ev_code), 32'h45);
    @(posedge clk); #1 dataready = 1'b0;
    wait_ms(22);
    @(negedge clk); chk("pre_release_held", 32'(key_held), 32'(1));
    wait_ms(8);
    checkpoint("single");
    chk("single_held_code", 32'(held_code), 32'h45);

    // Address filter: rejected here, accepted by the unfiltered instance.
    drive_edge(8'h12, 8'h33);
    repeat (3) @(negedge clk);
    chk("filt_valid", 32'(ev_valid), 32'(0));
    chk("nf_valid", 32'(nf_ev_valid), 32'(1));
    chk("nf_type", 32'(nf_ev_type), 32'(T_PRESS));
    chk("nf_code", 32'(nf_ev_code), 32'h33);
    chk("nf_count", 32'(nf_fifo_count), 32'(1));
    chk("nf_overflow", 32'(nf_overflow), 32'(0));
    chk("nf_held", 32'(nf_key_held), 32'(1));
    chk("nf_held_code", 32'(nf_held_code), 32'h33);
    @(posedge clk); #1 dataready = 1'b0;
    wait_ms(5);
    checkpoint("filter");

    // Repeats: edges ~11.4 ms apart, repeats only after 40 ms.
    frame(8'h00, 8'h16);
    for (int k = 0; k < 9; k++) begin
      wait_ms(11);
      frame(8'h00, 8'h16);
    end
    wait_ms(18);
    checkpoint("repeat_held");
    wait_ms(12);
    checkpoint("repeat_rel");

    // Key swap: release/0C and press/18 on consecutive cycles.
    frame(8'h00, 8'h0C);
    wait_ms(5);
    frame(8'h00, 8'h18);
    wait_ms(2);
    @(negedge clk);
    chk("swap_nobs", 32'(obs_q.size()), 32'(3));
    chk("swap_adjacent", 32'(obs_cyc[2] - obs_cyc[1]), 32'(1));
    wait_ms(30);
    checkpoint("swap");

    // Randomized frames; gaps steered clear of the timer boundaries.
    for (int s = 0; s < 20; s++) begin
      w = ($urandom_range(0, 2) == 0) ? int'($urandom_range(30, 45)) : int'($urandom_range(3, 20));
      d = 8'h20 + 8'($urandom_range(0, 2));
      a = ($urandom_range(0, 5) == 0) ? 8'h5A : 8'h00;
      for (int k = 0; k < 4; k++) begin
        te = now_cyc() + longint'(w) * 10 + 2;
        dd = te - m_last;
        ss = te - m_press;
        if (m_held && dd > HOLD_MAX && dd < REL_MIN) w += 8;
        else if (m_held && a == 8'h00 && dd <= HOLD_MAX && d == m_code && ss > REP_NO && ss < REP_YES) w += 30;
      end
      wait_ms(w);
      checkpoint($sformatf("rnd%0d", s));
      frame(a, d);
    end
    wait_ms(30);
    checkpoint("rnd_end");

    // Backpressure: six events into a four-entry FIFO.
    @(posedge clk); #1 ev_ready = 1'b0;
    frame(8'h00, 8'hA1);
    wait_ms(5);
    frame(8'h00, 8'hA2);
    wait_ms(5);
    frame(8'h00, 8'hA3);
    wait_ms(30);
    @(negedge clk);
    model_advance(now_cyc());
    chk("bp_count", 32'(fifo_count), 32'(exp_q.size()));
    chk("bp_overflow", 32'(overflow), 32'(exp_ovf));
    chk("bp_valid", 32'(ev_valid), 32'(1));
    chk("bp_head", 32'({ev_type, ev_code}), 32'(exp_q[0]));
    @(posedge clk); #1 ev_ready = 1'b1;
    wait_ms(1);
    checkpoint("bp_drain");
    chk("bp_overflow_sticky", 32'(overflow), 32'(exp_ovf));
    chk("bp_empty", 32'(fifo_count), 32'(0));

    // Reset while held with two queued repeats and dataready high.
    frame(8'h00, 8'hB5);
    wait_ms(15);
    frame(8'h00, 8'hB5);
    wait_ms(15);
    frame(8'h00, 8'hB5);
    wait_ms(2);
    checkpoint("rst_pre");
    ev_ready = 1'b0;
    wait_ms(13);
    frame(8'h00, 8'hB5);
    wait_ms(15);
    frame(8'h00, 8'hB5);
    wait_ms(2);
    @(negedge clk);
    chk("rst_queued", 32'(fifo_count), 32'(exp_q.size()));
    chk("rst_held_before", 32'(key_held), 32'(m_held));
    @(posedge clk); #1;
    address = 8'h00; data = 8'hB5; dataready = 1'b1; rst = 1'b1;
    #1;
    chk_reset("rst_mid");
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    m_held = 1'b0; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; ev_ready = 1'b1;
    wait_ms(3);
    @(negedge clk);
    chk("post_rst_valid", 32'(ev_valid), 32'(0));
    chk("post_rst_held", 32'(key_held), 32'(0));
    chk("post_rst_count", 32'(fifo_count), 32'(0));
    chk("post_rst_nobs", 32'(obs_q.size()), 32'(0));
    dataready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nec_key_events.md
# nec_key_events

Downstream consumer of the NEC IR decoder. Turns the decoder's level-style `address`/`data`/`dataready` outputs into discrete key events (press, repeat, release). Events are buffered in a small FIFO with a valid/ready handshake, so the user-interface logic can drain them at its own pace. Filters by device address and synthesises release events from a hold timeout.

## Interface
- `CLOCK_INPUT`, 25000000: clock frequency in Hz; `TICKS_PER_MS = CLOCK_INPUT/1000` clocks form one ms tick.
- `DEVICE_ADDR`, 8'h00: accepted NEC address.
- `ADDR_FILTER`, 1: 1 = ignore frames whose `address != DEVICE_ADDR`; 0 = accept all.
- `REPEAT_DELAY_MS`, 400: minimum ms after a press before repeat events are emitted.
- `RELEASE_MS`, 250: ms without a `dataready` rising edge after which a held key is released.
- `FIFO_DEPTH`, 8: event FIFO entries, power of two, ≥2.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `address` in 8: decoder address, stable while `dataready` high.
- `data` in 8: decoder command, stable while `dataready` high.
- `dataready` in 1: decoder valid; each rising edge = one frame or repeat code.
- `ev_valid` out 1: FIFO head valid.
- `ev_ready` in 1: consumer accepts head when `ev_valid & ev_ready`.
- `ev_type` out 2: 2'b01 press, 2'b10 repeat, 2'b11 release.
- `ev_code` out 8: command byte of the event.
- `fifo_count` out log2(FIFO_DEPTH)+1: entries stored.
- `overflow` out 1: sticky; an event was dropped on a full FIFO.
- `key_held` out 1: a key is currently considered held.
- `held_code` out 8: code of the held key (last value kept when not held).

## Operation
- Edge detect: `dr_d` registers `dataready` (reset value 1, so a high level at reset release is not an edge); `rise = dataready & ~dr_d`.
- Accepted edge: `rise` and (`ADDR_FILTER==0` or `address==DEVICE_ADDR`). Rejected edges have no effect on state or timers.
- Ms timer: prescaler counts 0..TICKS_PER_MS-1 and emits `ms_tick` at wrap. Prescaler free-runs, so the first ms after a clear is up to one ms short. `idle_ms` and `press_ms` are 16-bit, increment on `ms_tick`, and saturate at 16'hFFFF.
- States:
  - IDLE: accepted edge → push {press, data}; `held_code=data`; clear `idle_ms`, `press_ms`; → HELD.
  - HELD, accepted edge with `data==held_code`: clear `idle_ms`. If `press_ms >= REPEAT_DELAY_MS`, push {repeat, held_code}. Stay in HELD.
  - HELD, accepted edge with `data!=held_code`: push {release, held_code}; latch new code in `held_code`; clear both timers; → SWAP.
  - HELD, no accepted edge and `idle_ms >= RELEASE_MS`: push {release, held_code} → IDLE. When both conditions hold in the same cycle, the edge wins.
  - SWAP: push {press, held_code} unconditionally → HELD (one cycle). An edge arriving in SWAP is ignored.
- `key_held` = state is HELD or SWAP.
- FIFO: registered, first-word-fall-through, entries {type, code}.
  - Push when full and no pop that cycle: entry dropped, `overflow` set. The state machine advances regardless.
  - Push and pop in the same cycle while full: both take effect, count unchanged.
  - `ev_type`/`ev_code` are held stable while `ev_valid & ~ev_ready`.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `ev_valid=0`, `ev_type=0`, `ev_code=0`, `fifo_count=0`, `overflow=0`, `key_held=0`, `held_code=0`. State IDLE, timers and prescaler 0, FIFO emptied.
- Reset mid-operation discards queued and pending events. No release is emitted.
- Latency: `rise` seen in cycle N → push in cycle N+1 → `ev_valid` high in N+2 if the FIFO was empty.
- Swap: release pushed in N+1, press pushed in N+2.
- Throughput: one push and one pop per cycle.
- Release is pushed in the cycle after `idle_ms` reaches RELEASE_MS.

## Test plan
Bench uses CLOCK_INPUT=10000 (10 clk/ms), REPEAT_DELAY_MS=40, RELEASE_MS=25, FIFO_DEPTH=4, DEVICE_ADDR=8'h00, `ev_ready=1` unless stated.
- Single press: one `dataready` pulse, addr 00, data 8'h45 → press/45 with `ev_valid` at N+2. Then release/45 ~250 clk later; `key_held` falls to 0.
- Repeats: press 8'h16, then rising edges every 11 ms for 100 ms → no repeat before 40 ms, then one repeat/16 per edge. Release 25 ms after the last edge.
- Address filter: frame with addr 8'h12 → no event, `key_held` stays 0. With ADDR_FILTER=0 → press emitted.
- Key swap: press 8'h0C held, then an edge with data 8'h18 → release/0C then press/18 on consecutive pushes, and no release/18 in between.
- Backpressure: `ev_ready=0`, generate 6 events → `fifo_count` saturates at 4, `overflow=1`. Draining returns the first 4 events in order.
- Reset: assert `rst` while HELD with 2 queued events → all outputs return to reset values at once. No event appears when `rst` is released while `dataready` is high.
